// File: rtl/sifh_peak_finder_pkg.sv
// Shared constants and state type for the SiFH per-pixel histogram peak finder.
package sifh_peak_finder_pkg;

   localparam int unsigned BIN_NUM   = 256;
   localparam int unsigned BIN_W     = 8;
   localparam int unsigned PIXEL_NUM = 4;
   localparam int unsigned PIX_W     = 2;
   localparam int unsigned ADDR_W    = PIX_W + BIN_W;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned WIN       = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      EMIT  = 2'd3
   } peakState_t;

endpackage

// File: rtl/sifh_peak_finder_if.sv
// Histogram SRAM port-b read bus plus the per-pixel peak result bus.
interface sifh_peak_finder_if;
   import sifh_peak_finder_pkg::*;

   logic              start;
   logic [ADDR_W-1:0] raddr;
   logic              rEnable;
   logic              readFlag;
   logic [CNT_W-1:0]  counts;
   logic              busy;
   logic              peak_valid;
   logic [PIX_W-1:0]  peak_pixel;
   logic [BIN_W-1:0]  peak_bin;
   logic [CNT_W-1:0]  peak_cnt;
   logic [BIN_W-1:0]  th_lo;
   logic [BIN_W-1:0]  th_hi;
   logic              done;

   modport master (
      input  start, counts,
      output raddr, rEnable, readFlag, busy, peak_valid, peak_pixel,
             peak_bin, peak_cnt, th_lo, th_hi, done
   );

   modport slave (
      output start, counts,
      input  raddr, rEnable, readFlag, busy, peak_valid, peak_pixel,
             peak_bin, peak_cnt, th_lo, th_hi, done
   );

endinterface

// File: rtl/sifh_max_tracker.sv
// Running max over one pixel's bins, plus the clamped coincidence window around it.
module sifh_max_tracker
   import sifh_peak_finder_pkg::*;
(
   input  logic             clk,
   input  logic             res,
   input  logic             dataValid,
   input  logic [BIN_W-1:0] dataBin,
   input  logic [CNT_W-1:0] dataCnt,
   output logic [BIN_W-1:0] nextBin_c,
   output logic [CNT_W-1:0] nextCnt_c,
   output logic [BIN_W-1:0] thLo_c,
   output logic [BIN_W-1:0] thHi_c
);

   logic [BIN_W-1:0] bestBin;
   logic [CNT_W-1:0] bestCnt;
   logic             take;
   logic [BIN_W:0]   wideLo;
   logic [BIN_W:0]   wideHi;

   // Bin 0 always loads; later bins need a strictly larger count so ties keep the lowest bin.
   always_comb begin
      take      = dataValid && ((dataBin == '0) || (dataCnt > bestCnt));
      nextBin_c = take ? dataBin : bestBin;
      nextCnt_c = take ? dataCnt : bestCnt;

      wideLo = {1'b0, nextBin_c} - (BIN_W+1)'(WIN);
      wideHi = {1'b0, nextBin_c} + (BIN_W+1)'(WIN);
      thLo_c = wideLo[BIN_W] ? '0 : wideLo[BIN_W-1:0];
      thHi_c = (wideHi > (BIN_W+1)'(BIN_NUM-1)) ? BIN_W'(BIN_NUM-1) : wideHi[BIN_W-1:0];
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         bestBin <= '0;
         bestCnt <= '0;
      end else begin
         bestBin <= nextBin_c;
         bestCnt <= nextCnt_c;
      end
   end

endmodule

// File: rtl/sifh_peak_finder.sv
// Scans every pixel histogram on SRAM port b and emits one peak/window result per pixel.
module sifh_peak_finder
   import sifh_peak_finder_pkg::*;
(
   input  logic               clk,
   input  logic               res,
   sifh_peak_finder_if.master bus
);

   peakState_t       state;
   logic             dataValid;
   logic [BIN_W-1:0] dataBin;
   logic [PIX_W-1:0] curPixel;
   logic [BIN_W-1:0] curBin;
   logic             lastPixel;
   logic             lastBin;
   logic [BIN_W-1:0] nextBin_c;
   logic [CNT_W-1:0] nextCnt_c;
   logic [BIN_W-1:0] thLo_c;
   logic [BIN_W-1:0] thHi_c;

   assign curPixel  = bus.raddr[ADDR_W-1 -: PIX_W];
   assign curBin    = bus.raddr[BIN_W-1:0];
   assign lastPixel = (curPixel == PIX_W'(PIXEL_NUM-1));
   assign lastBin   = (curBin == BIN_W'(BIN_NUM-1));

   sifh_max_tracker u_tracker (
      .clk       (clk),
      .res       (res),
      .dataValid (dataValid),
      .dataBin   (dataBin),
      .dataCnt   (bus.counts),
      .nextBin_c (nextBin_c),
      .nextCnt_c (nextCnt_c),
      .thLo_c    (thLo_c),
      .thHi_c    (thHi_c)
   );

   // Results latch on the DRAIN edge, when the tracker sees the final bin's data.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state          <= IDLE;
         bus.raddr      <= '0;
         bus.rEnable    <= 1'b1;
         bus.readFlag   <= 1'b0;
         bus.busy       <= 1'b0;
         bus.peak_valid <= 1'b0;
         bus.done       <= 1'b0;
         bus.peak_pixel <= '0;
         bus.peak_bin   <= '0;
         bus.peak_cnt   <= '0;
         bus.th_lo      <= '0;
         bus.th_hi      <= '0;
         dataValid      <= 1'b0;
         dataBin        <= '0;
      end else begin
         bus.peak_valid <= 1'b0;
         bus.done       <= 1'b0;
         dataValid      <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state        <= READ;
                  bus.raddr    <= '0;
                  bus.rEnable  <= 1'b0;
                  bus.readFlag <= 1'b1;
                  bus.busy     <= 1'b1;
               end
            end
            READ: begin
               dataValid <= 1'b1;
               dataBin   <= curBin;
               if (lastBin) begin
                  state        <= DRAIN;
                  bus.rEnable  <= 1'b1;
                  bus.readFlag <= 1'b0;
               end else begin
                  bus.raddr <= ADDR_W'(bus.raddr + 1'b1);
               end
            end
            DRAIN: begin
               state          <= EMIT;
               bus.peak_valid <= 1'b1;
               bus.done       <= lastPixel;
               bus.peak_pixel <= curPixel;
               bus.peak_bin   <= nextBin_c;
               bus.peak_cnt   <= nextCnt_c;
               bus.th_lo      <= thLo_c;
               bus.th_hi      <= thHi_c;
            end
            EMIT: begin
               if (lastPixel) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  state        <= READ;
                  bus.raddr    <= {PIX_W'(curPixel + 1'b1), BIN_W'(0)};
                  bus.rEnable  <= 1'b0;
                  bus.readFlag <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sifh_peak_finder.sv
// Randomised bench for sifh_peak_finder against a per-pixel max/window reference model.
module tb_sifh_peak_finder;
   import sifh_peak_finder_pkg::*;

   localparam int PERIOD = int'(BIN_NUM) + 2;
   localparam int TOTAL  = int'(PIXEL_NUM) * PERIOD;
   localparam int NBIN   = int'(BIN_NUM);
   localparam int NPIX   = int'(PIXEL_NUM);
   localparam int HW     = int'(WIN);

   logic clk = 1'b0;
   logic res = 1'b1;
   always #5 clk = ~clk;

   sifh_peak_finder_if bus();

   sifh_peak_finder dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   logic [CNT_W-1:0] mem [NPIX*NBIN];

   // Synchronous SRAM read port: data one cycle after the address.
   always @(posedge clk)
      if (!bus.rEnable && bus.readFlag) bus.counts <= mem[bus.raddr];

   int vectors     = 0;
   int miscompares = 0;

   task automatic checkVal(input string tag, input int obs, input int exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Peak = lowest bin holding the largest count; window clamped to [0, BIN_NUM-1].
   task automatic refPeak(input int p, output int bin, output int cnt, output int lo, output int hi);
      bin = 0;
      cnt = int'(mem[p*NBIN]);
      for (int b = 1; b < NBIN; b++)
         if (int'(mem[p*NBIN+b]) > cnt) begin
            cnt = int'(mem[p*NBIN+b]);
            bin = b;
         end
      lo = (bin >= HW) ? bin - HW : 0;
      hi = (bin + HW > NBIN - 1) ? NBIN - 1 : bin + HW;
   endtask

   task automatic checkIdle(input string tag);
      checkVal({tag, "_raddr"},      int'(bus.raddr), 0);
      checkVal({tag, "_rEnable"},    int'(bus.rEnable), 1);
      checkVal({tag, "_readFlag"},   int'(bus.readFlag), 0);
      checkVal({tag, "_busy"},       int'(bus.busy), 0);
      checkVal({tag, "_peak_valid"}, int'(bus.peak_valid), 0);
      checkVal({tag, "_done"},       int'(bus.done), 0);
      checkVal({tag, "_peak_pixel"}, int'(bus.peak_pixel), 0);
      checkVal({tag, "_peak_bin"},   int'(bus.peak_bin), 0);
      checkVal({tag, "_peak_cnt"},   int'(bus.peak_cnt), 0);
      checkVal({tag, "_th_lo"},      int'(bus.th_lo), 0);
      checkVal({tag, "_th_hi"},      int'(bus.th_hi), 0);
   endtask

   // One full scan; start held holdCycles edges, plus an extra pulse sampled at edge k+pulseAt+1.
   task automatic runScan(input int holdCycles, input int pulseAt);
      int strobes = 0;
      int dones   = 0;
      int lastBin = 0;
      int eb, ec, el, eh, phase, p;
      @(posedge clk); #1 bus.start = 1'b1;
      for (int n = 0; n < TOTAL + 4; n++) begin
         @(posedge clk); #1;
         bus.start = ((n + 1) < holdCycles) || (n == pulseAt);
         phase = n % PERIOD;
         p     = n / PERIOD;
         if (n < TOTAL) begin
            checkVal("busy", int'(bus.busy), 1);
            if (phase < NBIN) begin
               checkVal("raddr", int'(bus.raddr), p*NBIN + phase);
               checkVal("rEnable", int'(bus.rEnable), 0);
               checkVal("readFlag", int'(bus.readFlag), 1);
            end else begin
               checkVal("rEnable_gap", int'(bus.rEnable), 1);
               checkVal("readFlag_gap", int'(bus.readFlag), 0);
            end
            checkVal("peak_valid", int'(bus.peak_valid), int'(phase == PERIOD-1));
            checkVal("done", int'(bus.done), int'(n == TOTAL-1));
            if (phase == PERIOD-1) begin
               refPeak(p, eb, ec, el, eh);
               checkVal("peak_pixel", int'(bus.peak_pixel), p);
               checkVal("peak_bin", int'(bus.peak_bin), eb);
               checkVal("peak_cnt", int'(bus.peak_cnt), ec);
               checkVal("th_lo", int'(bus.th_lo), el);
               checkVal("th_hi", int'(bus.th_hi), eh);
               lastBin = eb;
            end else if (p > 0 && phase == NBIN/2) begin
               checkVal("hold_bin", int'(bus.peak_bin), lastBin);
            end
         end else begin
            checkVal("busy_after", int'(bus.busy), 0);
            checkVal("peak_valid_after", int'(bus.peak_valid), 0);
            checkVal("done_after", int'(bus.done), 0);
            checkVal("rEnable_after", int'(bus.rEnable), 1);
            checkVal("readFlag_after", int'(bus.readFlag), 0);
         end
         strobes += int'(bus.peak_valid);
         dones   += int'(bus.done);
      end
      bus.start = 1'b0;
      checkVal("strobe_count", strobes, NPIX);
      checkVal("done_count", dones, 1);
   endtask

   initial begin
      bus.start = 1'b0;
      for (int i = 0; i < NPIX*NBIN; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1 checkIdle("reset");
      res = 1'b0;

      // Spike, tie, all-zero pixel, low-edge clamp.
      mem[0*NBIN + 100] = 8'd50;
      mem[1*NBIN + 10]  = 8'd7;
      mem[1*NBIN + 200] = 8'd7;
      mem[3*NBIN + 3]   = 8'd9;
      mem[3*NBIN + 40]  = 8'd4;
      runScan(1, -1);

      // Random histograms, high-edge peak; start held 5 cycles and pulsed mid-scan.
      for (int i = 0; i < NPIX*NBIN; i++) mem[i] = CNT_W'($urandom);
      for (int b = 0; b < NBIN; b++) mem[1*NBIN + b] = CNT_W'($urandom_range(0, 100));
      mem[1*NBIN + 250] = 8'd200;
      runScan(5, 600);

      // Reset during pixel 1 READ: outputs clear at once, nothing further emitted.
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (PERIOD + 40) @(posedge clk);
      #1 res = 1'b1;
      #1 checkIdle("midreset");
      repeat (3) @(posedge clk);
      #1 res = 1'b0;
      for (int n = 0; n < 2*PERIOD; n++) begin
         @(posedge clk); #1;
         checkVal("post_reset_valid", int'(bus.peak_valid), 0);
         checkVal("post_reset_done", int'(bus.done), 0);
         checkVal("post_reset_busy", int'(bus.busy), 0);
      end

      // Fresh scan: peak at top bin, flat pixel, start pulsed in the done cycle (ignored).
      for (int i = 0; i < NPIX*NBIN; i++) mem[i] = CNT_W'($urandom_range(0, 254));
      mem[0*NBIN + 255] = 8'd255;
      for (int b = 0; b < NBIN; b++) mem[3*NBIN + b] = 8'd33;
      runScan(1, TOTAL - 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
